// File: rtl/iob_bus_pkg.sv
// iob_bus_pkg: shared width helpers, strobe mask
// and REQ/RESP field offsets for IOb bus wrappers.
package iob_bus_pkg;

  function automatic int off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Lanes past bit 63 are simply shifted out.
  function automatic logic [63:0] strb_mask(
    input logic [1:0] size,
    input logic [5:0] off,
    input int         offw
  );
    int          s;
    logic [63:0] lanes;
    s = (int'(size) < offw) ? int'(size) : offw;
    lanes = (64'd1 << (1 << s)) - 64'd1;
    return lanes << off;
  endfunction

  // REQ  = {valid, addr, wdata, wstrb}
  // RESP = {rdata, ready}
  function automatic int req_w(input int aw, input int dw);
    return 1 + aw + dw + dw / 8;
  endfunction

  function automatic int req_valid_off(input int aw, input int dw);
    return req_w(aw, dw) - 1;
  endfunction

  function automatic int req_addr_off(input int dw);
    return dw + dw / 8;
  endfunction

  function automatic int req_wdata_off(input int dw);
    return dw / 8;
  endfunction

  localparam int REQ_WSTRB_OFF = 0;

  function automatic int resp_w(input int dw);
    return dw + 1;
  endfunction

  localparam int RESP_READY_OFF = 0;
  localparam int RESP_RDATA_OFF = 1;

endpackage

// File: rtl/iob_cpu_bus_bridge_if.sv
// CPU command/response stream plus IOb native bus.
// slave = bridge side, master = CPU/memory side.
interface iob_cpu_bus_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_wr;
  logic [1:0]          cmd_size;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;
  logic                rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                iob_valid;
  logic [ADDR_W-1:0]   iob_addr;
  logic [DATA_W-1:0]   iob_wdata;
  logic [DATA_W/8-1:0] iob_wstrb;
  logic [DATA_W-1:0]   iob_rdata;
  logic                iob_ready;

  modport slave (
    input  cmd_valid, cmd_wr, cmd_size,
    input  cmd_addr, cmd_wdata,
    input  iob_rdata, iob_ready,
    output cmd_ready, rsp_valid, rsp_rdata,
    output iob_valid, iob_addr,
    output iob_wdata, iob_wstrb
  );

  modport master (
    output cmd_valid, cmd_wr, cmd_size,
    output cmd_addr, cmd_wdata,
    output iob_rdata, iob_ready,
    input  cmd_ready, rsp_valid, rsp_rdata,
    input  iob_valid, iob_addr,
    input  iob_wdata, iob_wstrb
  );
endinterface

// File: rtl/iob_bridge_fifo.sv
// Register-based sync FIFO, async active-high reset.
// Ports: push/din, pop/dout, full, empty, level.
module iob_bridge_fifo #(
  parameter int W       = 8,
  parameter int DEPTH_W = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic [W-1:0]   din,
  input  logic           pop,
  output logic [W-1:0]   dout,
  output logic           full,
  output logic           empty,
  output logic [DEPTH_W:0] level
);
  localparam int DEPTH = 1 << DEPTH_W;

  logic [W-1:0]       mem [DEPTH];
  logic [DEPTH_W-1:0] wr_ptr;
  logic [DEPTH_W-1:0] rd_ptr;
  logic               do_push;
  logic               do_pop;

  // Level reaches 2**DEPTH_W only when full.
  assign full    = level[DEPTH_W];
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        level <= level + 1'b1;
      else if (!do_push && do_pop)
        level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/iob_cpu_bus_bridge.sv
// CPU stream -> IOb bridge: command FIFO, byte strobes,
// boot remap, in-order single outstanding transfer.
// Ports: clk, rst, boot, bus (slave), pending.
module iob_cpu_bus_bridge
  import iob_bus_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int CMD_DEPTH_W  = 1,
  parameter int IBUS_MODE    = 0,
  parameter int RSP_ON_WRITE = 0,
  parameter int REMAP_EN     = 0,
  parameter int E_BIT        = ADDR_W - 2,
  parameter int P_BIT        = ADDR_W - 3
) (
  input  logic clk,
  input  logic rst,
  input  logic boot,
  iob_cpu_bus_bridge_if.slave bus,
  output logic [CMD_DEPTH_W:0] pending
);
  localparam int OFF_W = off_w(DATA_W);
  localparam int SW    = DATA_W / 8;

  typedef struct packed {
    logic              is_read;
    logic [SW-1:0]     wstrb;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  localparam int EW = $bits(entry_t);

  entry_t            push_ent;
  entry_t            head;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] off_full;
  logic [63:0]       mask;
  logic [ADDR_W-1:0] addr_map;

  assign off_full = bus.cmd_addr & ADDR_W'(SW - 1);
  assign mask = strb_mask(bus.cmd_size,
                          off_full[5:0], OFF_W);

  always_comb begin
    push_ent       = '0;
    push_ent.addr  = bus.cmd_addr;
    push_ent.wdata = bus.cmd_wdata;
    if (IBUS_MODE != 0) begin
      push_ent.is_read = 1'b1;
    end else begin
      push_ent.is_read = ~bus.cmd_wr;
      push_ent.wstrb = bus.cmd_wr ? mask[SW-1:0]
                                  : '0;
    end
  end

  assign push          = bus.cmd_valid & ~full;
  assign pop           = bus.iob_ready & ~empty;
  assign bus.cmd_ready = ~full;

  iob_bridge_fifo #(
    .W       (EW),
    .DEPTH_W (CMD_DEPTH_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_ent),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (pending)
  );

  // MSB follows the live boot level while driven.
  always_comb begin
    addr_map = head.addr;
    if (REMAP_EN != 0) begin
      if (IBUS_MODE != 0)
        addr_map[ADDR_W-1] = ~boot;
      else
        addr_map[ADDR_W-1] =
          (head.addr[E_BIT] ^ ~boot) &
          ~head.addr[P_BIT];
    end
  end

  assign bus.iob_valid = ~empty;
  assign bus.iob_addr  = empty ? '0 : addr_map;
  assign bus.iob_wdata = empty ? '0 : head.wdata;
  assign bus.iob_wstrb = empty ? '0 : head.wstrb;

  assign bus.rsp_valid = pop &
    (head.is_read | (RSP_ON_WRITE != 0));
  assign bus.rsp_rdata = bus.rsp_valid ?
    bus.iob_rdata : '0;

endmodule

// File: tb/tb_iob_cpu_bus_bridge.sv
// Bench for iob_cpu_bus_bridge: three configs,
// directed steps plus random traffic vs a queue model.
module tb_iob_cpu_bus_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic boot = 1'b1;
  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;

  iob_cpu_bus_bridge_if #(.ADDR_W(32), .DATA_W(32)) ba();
  iob_cpu_bus_bridge_if #(.ADDR_W(32), .DATA_W(64)) bb();
  iob_cpu_bus_bridge_if #(.ADDR_W(32), .DATA_W(32)) bc();

  logic [2:0] pend_a;
  logic [1:0] pend_b;
  logic [1:0] pend_c;

  iob_cpu_bus_bridge #(
    .ADDR_W(32), .DATA_W(32), .CMD_DEPTH_W(2),
    .IBUS_MODE(0), .RSP_ON_WRITE(0), .REMAP_EN(1),
    .E_BIT(30), .P_BIT(29)
  ) dut_a (
    .clk(clk), .rst(rst), .boot(boot),
    .bus(ba), .pending(pend_a)
  );

  iob_cpu_bus_bridge #(
    .ADDR_W(32), .DATA_W(64), .CMD_DEPTH_W(1),
    .IBUS_MODE(0), .RSP_ON_WRITE(1), .REMAP_EN(0),
    .E_BIT(30), .P_BIT(29)
  ) dut_b (
    .clk(clk), .rst(rst), .boot(boot),
    .bus(bb), .pending(pend_b)
  );

  iob_cpu_bus_bridge #(
    .ADDR_W(32), .DATA_W(32), .CMD_DEPTH_W(1),
    .IBUS_MODE(1), .RSP_ON_WRITE(0), .REMAP_EN(1),
    .E_BIT(30), .P_BIT(29)
  ) dut_c (
    .clk(clk), .rst(rst), .boot(boot),
    .bus(bc), .pending(pend_c)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        rd;
  } ent_t;

  ent_t q[$];

  logic        s_valid, s_ready, s_rsp, s_acc;
  logic [31:0] s_addr, s_rdata;
  logic [3:0]  s_wstrb;
  logic [2:0]  s_pend;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Lane i is written when off <= i < off + bytes.
  function automatic logic [3:0] exp_strb(
    input logic wr, input logic [1:0] sz,
    input logic [31:0] ad);
    int nb, off;
    logic [3:0] m;
    m = '0;
    if (!wr) return m;
    nb = (sz >= 2) ? 4 : ((sz == 1) ? 2 : 1);
    off = int'(ad % 4);
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + nb) m[i] = 1'b1;
    return m;
  endfunction

  // Booting: MSB copies bit30; else inverted bit30;
  // peripheral space (bit29) always forces 0.
  function automatic logic [31:0] exp_addr(
    input logic [31:0] a, input logic b);
    logic [31:0] r;
    r = a;
    if (a[29]) r[31] = 1'b0;
    else if (b) r[31] = a[30];
    else r[31] = ~a[30];
    return r;
  endfunction

  task automatic cyc_a(
    input logic v, input logic wr,
    input logic [1:0] sz, input logic [31:0] ad,
    input logic [31:0] wd, input logic rdy,
    input logic [31:0] rdat);
    logic ne, cmp, acc, erd;
    ent_t e;
    ba.cmd_valid = v;
    ba.cmd_wr = wr;
    ba.cmd_size = sz;
    ba.cmd_addr = ad;
    ba.cmd_wdata = wd;
    ba.iob_ready = rdy;
    ba.iob_rdata = rdat;
    @(negedge clk);
    s_valid = ba.iob_valid;
    s_ready = ba.cmd_ready;
    s_rsp = ba.rsp_valid;
    s_rdata = ba.rsp_rdata;
    s_addr = ba.iob_addr;
    s_wstrb = ba.iob_wstrb;
    s_pend = pend_a;
    s_acc = v & ba.cmd_ready;
    ne = (q.size() > 0);
    chk("a_cmd_ready", ba.cmd_ready, q.size() < 4);
    chk("a_pending", pend_a, q.size());
    chk("a_iob_valid", ba.iob_valid, ne);
    if (ne) begin
      chk("a_iob_addr", ba.iob_addr,
          exp_addr(q[0].addr, boot));
      chk("a_iob_wdata", ba.iob_wdata, q[0].wdata);
      chk("a_iob_wstrb", ba.iob_wstrb, q[0].wstrb);
      erd = q[0].rd;
    end else begin
      chk("a_idle_bus",
          {ba.iob_addr, ba.iob_wdata}, 64'd0);
      chk("a_idle_wstrb", ba.iob_wstrb, 4'd0);
      erd = 1'b0;
    end
    cmp = rdy & ne;
    chk("a_rsp_valid", ba.rsp_valid, cmp & erd);
    chk("a_rsp_rdata", ba.rsp_rdata,
        (cmp & erd) ? rdat : 32'd0);
    acc = v && (q.size() < 4);
    @(posedge clk);
    if (cmp) void'(q.pop_front());
    if (acc) begin
      e.addr = ad;
      e.wdata = wd;
      e.wstrb = exp_strb(wr, sz, ad);
      e.rd = ~wr;
      q.push_back(e);
    end
    #1;
    ba.cmd_valid = 1'b0;
    ba.iob_ready = 1'b0;
  endtask

  task automatic idle_a(input logic rdy);
    cyc_a(1'b0, 1'b0, 2'd0, 32'd0, 32'd0,
          rdy, $urandom);
  endtask

  task automatic b_xfer(input string tag,
    input logic wr, input logic [1:0] sz,
    input logic [31:0] ad, input logic [7:0] es);
    logic [63:0] wd, rd;
    wd = {$urandom, $urandom};
    rd = {$urandom, $urandom};
    bb.cmd_valid = 1'b1;
    bb.cmd_wr = wr;
    bb.cmd_size = sz;
    bb.cmd_addr = ad;
    bb.cmd_wdata = wd;
    @(posedge clk);
    #1;
    bb.cmd_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_valid"}, bb.iob_valid, 1);
    chk({tag, "_wstrb"}, bb.iob_wstrb, es);
    chk({tag, "_addr"}, bb.iob_addr, ad);
    chk({tag, "_wdata"}, bb.iob_wdata, wd);
    chk({tag, "_pend1"}, pend_b, 1);
    @(posedge clk);
    #1;
    bb.iob_ready = 1'b1;
    bb.iob_rdata = rd;
    @(negedge clk);
    chk({tag, "_rsp"}, bb.rsp_valid, 1);
    chk({tag, "_rdata"}, bb.rsp_rdata, rd);
    @(posedge clk);
    #1;
    bb.iob_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_pend0"}, pend_b, 0);
    chk({tag, "_norsp"}, bb.rsp_valid, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic c_xfer(input string tag,
    input logic bt, input logic [31:0] ad);
    logic [31:0] rd;
    rd = $urandom;
    boot = bt;
    bc.cmd_valid = 1'b1;
    bc.cmd_wr = 1'b1;
    bc.cmd_size = 2'd2;
    bc.cmd_addr = ad;
    bc.cmd_wdata = $urandom;
    @(posedge clk);
    #1;
    bc.cmd_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_valid"}, bc.iob_valid, 1);
    chk({tag, "_wstrb"}, bc.iob_wstrb, 0);
    chk({tag, "_addr"}, bc.iob_addr,
        {~bt, ad[30:0]});
    @(posedge clk);
    #1;
    bc.iob_ready = 1'b1;
    bc.iob_rdata = rd;
    @(negedge clk);
    chk({tag, "_rsp"}, bc.rsp_valid, 1);
    chk({tag, "_rdata"}, bc.rsp_rdata, rd);
    @(posedge clk);
    #1;
    bc.iob_ready = 1'b0;
    boot = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  sz;
    logic [31:0] ad;
    logic [3:0]  es;
  } wcase_t;

  initial begin
    wcase_t wc[4];
    int nv, ncomp;
    logic fifth;
    logic [31:0] caddr[5];
    {ba.cmd_valid, ba.cmd_wr, ba.iob_ready} = '0;
    {bb.cmd_valid, bb.cmd_wr, bb.iob_ready} = '0;
    {bc.cmd_valid, bc.cmd_wr, bc.iob_ready} = '0;
    ba.cmd_size = '0; ba.cmd_addr = '0;
    ba.cmd_wdata = '0; ba.iob_rdata = '0;
    bb.cmd_size = '0; bb.cmd_addr = '0;
    bb.cmd_wdata = '0; bb.iob_rdata = '0;
    bc.cmd_size = '0; bc.cmd_addr = '0;
    bc.cmd_wdata = '0; bc.iob_rdata = '0;

    @(negedge clk);
    chk("rst_a_valid", ba.iob_valid, 0);
    chk("rst_a_ready", ba.cmd_ready, 1);
    chk("rst_a_pend", pend_a, 0);
    chk("rst_b_pend", pend_b, 0);
    chk("rst_c_valid", bc.iob_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_a(1'b0);

    // single read, ready after 3 cycles
    cyc_a(1, 0, 2, 32'h40, 0, 0, 0);
    nv = 0;
    for (int i = 0; i < 2; i++) begin
      idle_a(1'b0);
      nv += int'(s_valid);
      chk("rd_wstrb", s_wstrb, 0);
      chk("rd_norsp", s_rsp, 0);
    end
    cyc_a(0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
    nv += int'(s_valid);
    chk("rd_valid_cycles", nv, 3);
    chk("rd_rsp", s_rsp, 1);
    chk("rd_rdata", s_rdata, 32'hDEADBEEF);
    idle_a(1'b0);
    chk("rd_pend0", s_pend, 0);

    // write strobes, no write responses
    wc[0] = '{sz: 2'd0, ad: 32'h201, es: 4'h2};
    wc[1] = '{sz: 2'd1, ad: 32'h202, es: 4'hC};
    wc[2] = '{sz: 2'd2, ad: 32'h200, es: 4'hF};
    wc[3] = '{sz: 2'd1, ad: 32'h203, es: 4'h8};
    for (int i = 0; i < 4; i++) begin
      cyc_a(1, 1, wc[i].sz, wc[i].ad,
            $urandom, 0, 0);
      cyc_a(0, 0, 0, 0, 0, 1, $urandom);
      chk("wr_wstrb", s_wstrb, wc[i].es);
      chk("wr_norsp", s_rsp, 0);
    end

    // fill the 4-deep FIFO with memory stalled
    for (int k = 0; k < 4; k++)
      cyc_a(1, 0, 2, 32'h100 + 4 * k, 0, 0, 0);
    cyc_a(1, 0, 2, 32'h110, 0, 0, 0);
    chk("full_ready", s_ready, 0);
    chk("full_pend", s_pend, 4);
    chk("full_noacc", s_acc, 0);
    fifth = 1'b0;
    ncomp = 0;
    for (int i = 0; i < 15 && ncomp < 5; i++) begin
      cyc_a(~fifth, 0, 2, 32'h110, 0, 1, $urandom);
      if (s_valid) begin
        caddr[ncomp] = s_addr;
        ncomp++;
      end
      if (s_acc) fifth = 1'b1;
    end
    chk("full_fifth_acc", fifth, 1);
    chk("full_ncomp", ncomp, 5);
    for (int k = 0; k < 5; k++)
      chk("full_order", caddr[k], 32'h100 + 4 * k);

    // boot-dependent remap
    boot = 1'b1;
    cyc_a(1, 0, 2, 32'h4000_0000, 0, 0, 0);
    idle_a(1'b0);
    chk("remap_boot1", s_addr[31], 1);
    boot = 1'b0;
    idle_a(1'b0);
    chk("remap_boot0", s_addr[31], 0);
    idle_a(1'b1);
    cyc_a(1, 0, 2, 32'h2000_0000, 0, 0, 0);
    idle_a(1'b0);
    chk("remap_periph", s_addr[31], 0);
    idle_a(1'b1);
    boot = 1'b1;

    // reset with a read in flight and 2 queued
    cyc_a(1, 0, 2, 32'h300, 0, 0, 0);
    cyc_a(1, 1, 2, 32'h304, 1, 0, 0);
    cyc_a(1, 0, 2, 32'h308, 0, 0, 0);
    ba.iob_ready = 1'b1;
    ba.iob_rdata = 32'h1234_5678;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_rsp", ba.rsp_valid, 0);
    chk("rst_mid_valid", ba.iob_valid, 0);
    chk("rst_mid_pend", pend_a, 0);
    chk("rst_mid_ready", ba.cmd_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ba.iob_ready = 1'b0;
    q.delete();
    idle_a(1'b1);
    chk("rst_after_rsp", s_rsp, 0);

    // random traffic against the model
    for (int i = 0; i < 300; i++) begin
      boot = 1'($urandom_range(0, 1));
      cyc_a(1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)),
            $urandom, $urandom,
            ($urandom_range(0, 2) == 0), $urandom);
    end
    boot = 1'b1;
    for (int i = 0; i < 8; i++) idle_a(1'b1);

    // 64-bit lanes, writes also respond
    b_xfer("b_sz3", 1, 3, 32'h1000, 8'hFF);
    b_xfer("b_trunc", 1, 2, 32'h1006, 8'hC0);
    b_xfer("b_sz1", 1, 1, 32'h1003, 8'h18);
    b_xfer("b_read", 0, 0, 32'h1005, 8'h00);

    // instruction port: write ignored, remap ~boot
    c_xfer("c_boot1", 1'b1, 32'h0000_0100);
    c_xfer("c_boot0", 1'b0, 32'h0000_0104);
    c_xfer("c_msb", 1'b1, 32'h8000_0200);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
